// File: rtl/lsu_buffered_pkg.sv
// Shared LSU types: op encodings, byte-lane offset and load tracker entry.
// Imported by the LSU top and its load tracker.
package lsu_buffered_pkg;

  typedef enum logic [3:0] {
    LS_NOP = 4'h0,
    LS_LB  = 4'h1,
    LS_LH  = 4'h2,
    LS_LW  = 4'h3,
    LS_LBU = 4'h4,
    LS_LHU = 4'h5,
    LS_SB  = 4'h6,
    LS_SH  = 4'h7,
    LS_SW  = 4'h8
  } ls_op_t;

  typedef logic [1:0] lane_t;

  // Per-load metadata kept until the response returns;
  // rd is prepended by the LSU since its width is a parameter.
  typedef struct packed {
    ls_op_t op;
    lane_t  off;
  } ld_meta_t;

  function automatic logic op_is_load(ls_op_t op);
    return (op == LS_LB) || (op == LS_LH) || (op == LS_LW) ||
           (op == LS_LBU) || (op == LS_LHU);
  endfunction

  function automatic logic op_is_store(ls_op_t op);
    return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
  endfunction

endpackage

// File: rtl/lsu_ld_fifo.sv
// In-order load tracker: circular buffer with occupancy count.
// Push into a full buffer or pop from an empty one is ignored.
module lsu_ld_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Status and head read
  always_comb begin
    full    = (count == CW'(DEPTH));
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    rdata   = mem[rptr];
  end

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/lsu_buffered.sv
// Load/store unit with in-order tracking of outstanding loads.
// Stores are fire-and-forget; loads write back on in-order responses.
module lsu_buffered
  import lsu_buffered_pkg::*;
#(
  parameter int RD_W            = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  ls_op_t          ls_op,
  input  logic [RD_W-1:0] rd,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  input  logic [31:0]     imm_i,
  input  logic [31:0]     imm_s,
  output logic            ld_valid,
  output logic [RD_W-1:0] ld_rd,
  output logic [31:0]     ld_data,
  output logic            misalign,
  output logic [31:0]     misalign_addr,
  output logic            d_req_valid,
  input  logic            d_req_ready,
  output logic [31:0]     d_addr,
  output logic            d_we,
  output logic [3:0]      d_be,
  output logic [31:0]     d_wr_data,
  input  logic            d_rsp_valid,
  input  logic [31:0]     d_rd_data,
  output logic            busy,
  output logic            rsp_err
);

  localparam int MW = $bits(ld_meta_t);
  localparam int EW = RD_W + MW;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]     ea;
  logic            is_ld;
  logic            is_st;
  logic            mis;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic [EW-1:0]   wentry;
  logic [EW-1:0]   hentry;
  ld_meta_t        hmeta;
  logic [RD_W-1:0] hrd;
  logic [7:0]      hbyte;
  logic [15:0]     hhalf;
  logic [31:0]     ext;

  // Address generation and alignment check
  always_comb begin
    is_ld = op_is_load(ls_op);
    is_st = op_is_store(ls_op);
    ea    = rs1_data + (is_ld ? imm_i : imm_s);
    unique case (1'b1)
      (ls_op == LS_LH) || (ls_op == LS_LHU) || (ls_op == LS_SH):
        mis = ea[0];
      (ls_op == LS_LW) || (ls_op == LS_SW):
        mis = |ea[1:0];
      default:
        mis = 1'b0;
    endcase
  end

  // Handshake and tracker control
  always_comb begin
    req_ready   = mis | (d_req_ready & ~(is_ld & full));
    d_req_valid = req_valid & (is_ld | is_st) & ~mis & ~(is_ld & full);
    push        = d_req_valid & d_req_ready & is_ld;
    pop         = d_rsp_valid & ~empty;
    busy        = (count != '0);
    wentry      = {rd, ls_op, ea[1:0]};
  end

  // Memory request and store byte-lane placement
  always_comb begin
    d_addr    = {ea[31:2], 2'b00};
    d_we      = is_st;
    d_be      = 4'b1111;
    d_wr_data = rs2_data;
    unique case (1'b1)
      ls_op == LS_SB: begin
        d_be      = 4'b0001 << ea[1:0];
        d_wr_data = {4{rs2_data[7:0]}};
      end
      ls_op == LS_SH: begin
        d_be      = ea[1] ? 4'b1100 : 4'b0011;
        d_wr_data = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_ld_fifo #(
    .W     (EW),
    .DEPTH (MAX_OUTSTANDING),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (hentry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Load data extraction from the response word
  always_comb begin
    hrd   = hentry[EW-1:MW];
    hmeta = ld_meta_t'(hentry[MW-1:0]);
    hbyte = d_rd_data[{hmeta.off, 3'b000} +: 8];
    hhalf = hmeta.off[1] ? d_rd_data[31:16] : d_rd_data[15:0];
    unique case (1'b1)
      hmeta.op == LS_LB:  ext = {{24{hbyte[7]}}, hbyte};
      hmeta.op == LS_LBU: ext = {24'h0, hbyte};
      hmeta.op == LS_LH:  ext = {{16{hhalf[15]}}, hhalf};
      hmeta.op == LS_LHU: ext = {16'h0, hhalf};
      default:            ext = d_rd_data;
    endcase
  end

  // Registered writeback, misalign pulse and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid      <= 1'b0;
      ld_rd         <= '0;
      ld_data       <= '0;
      misalign      <= 1'b0;
      misalign_addr <= '0;
      rsp_err       <= 1'b0;
    end else begin
      ld_valid <= pop;
      if (pop) begin
        ld_rd   <= hrd;
        ld_data <= ext;
      end
      misalign <= req_valid & mis;
      if (req_valid & mis) misalign_addr <= ea;
      if (d_rsp_valid & empty) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_buffered.sv
// Directed self-checking bench for lsu_buffered.
// Scenario tasks run in sequence from one initial block.
module tb_lsu_buffered;
  import lsu_buffered_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  ls_op_t      ls_op;
  logic [3:0]  rd;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic        ld_valid;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wr_data;
  logic        d_rsp_valid;
  logic [31:0] d_rd_data;
  logic        busy;
  logic        rsp_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_buffered #(.RD_W(4), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .ls_op(ls_op), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm_i(imm_i), .imm_s(imm_s),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .misalign(misalign), .misalign_addr(misalign_addr),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
    .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
    .d_wr_data(d_wr_data),
    .d_rsp_valid(d_rsp_valid), .d_rd_data(d_rd_data),
    .busy(busy), .rsp_err(rsp_err)
  );

  task automatic drive(ls_op_t op, logic [3:0] r, logic [31:0] a,
                       logic [31:0] ii, logic [31:0] is, logic [31:0] s2);
    req_valid = 1'b1;
    ls_op     = op;
    rd        = r;
    rs1_data  = a;
    imm_i     = ii;
    imm_s     = is;
    rs2_data  = s2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 0; ls_op = LS_NOP; rd = 0;
    rs1_data = 0; rs2_data = 0; imm_i = 0; imm_s = 0;
    d_req_ready = 1; d_rsp_valid = 0; d_rd_data = 0;
    #3;
    n_chk++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ld_valid got %b want 0", ld_valid); end
    n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got %b want 0", misalign); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_chk++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    @(negedge clk);
    drive(LS_SB, 0, 32'h100, 0, 32'h3, 32'hAB); #1;
    n_chk++; if (d_addr !== 32'h100) begin n_fail++; $display("FAIL sb_addr got %h want 00000100", d_addr); end
    n_chk++; if (d_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", d_be); end
    n_chk++; if (d_wr_data !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_data got %h want abababab", d_wr_data); end
    n_chk++; if ({d_we, d_req_valid, req_ready} !== 3'b111) begin n_fail++; $display("FAIL sb_hs got %b want 111", {d_we, d_req_valid, req_ready}); end
    @(negedge clk);
    drive(LS_SH, 0, 32'h100, 0, 32'h2, 32'h12345678); #1;
    n_chk++; if (d_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b want 1100", d_be); end
    n_chk++; if (d_wr_data !== 32'h56785678) begin n_fail++; $display("FAIL sh_data got %h want 56785678", d_wr_data); end
    @(negedge clk);
    drive(LS_SW, 0, 32'h104, 0, 32'hFFFFFFFC, 32'hCAFEF00D); #1;
    n_chk++; if ({d_addr, d_be} !== {32'h100, 4'b1111}) begin n_fail++; $display("FAIL sw_addr_be got %h/%b want 00000100/1111", d_addr, d_be); end
    n_chk++; if (d_wr_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sw_data got %h want cafef00d", d_wr_data); end
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy got %b want 0", busy); end
    req_valid = 0;
  endtask

  task automatic do_load(ls_op_t op, logic [3:0] r, logic [31:0] a,
                         logic [31:0] ii, logic [31:0] rsp,
                         logic [31:0] exp);
    @(negedge clk);
    drive(op, r, a, ii, 0, 0); #1;
    n_chk++; if ({d_req_valid, d_we, d_be} !== 6'b101111) begin n_fail++; $display("FAIL ld_req op=%0d got %b want 101111", op, {d_req_valid, d_we, d_be}); end
    n_chk++; if (d_addr !== {a[31:2] + ii[31:2] + 30'(({2'b0, a[1:0]} + {2'b0, ii[1:0]}) >> 2), 2'b00}) begin n_fail++; $display("FAIL ld_addr op=%0d got %h", op, d_addr); end
    @(posedge clk); #1;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ld_busy op=%0d got %b want 1", op, busy); end
    @(negedge clk);
    req_valid = 0; d_rsp_valid = 1; d_rd_data = rsp;
    @(posedge clk); #1;
    n_chk++; if ({ld_valid, ld_rd} !== {1'b1, r}) begin n_fail++; $display("FAIL ld_wb op=%0d got %b/%0d want 1/%0d", op, ld_valid, ld_rd, r); end
    n_chk++; if (ld_data !== exp) begin n_fail++; $display("FAIL ld_data op=%0d got %h want %h", op, ld_data, exp); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ld_idle op=%0d got %b want 0", op, busy); end
    @(negedge clk);
    d_rsp_valid = 0;
    @(posedge clk); #1;
    n_chk++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL ld_pulse op=%0d got %b want 0", op, ld_valid); end
  endtask

  task automatic test_load();
    do_load(LS_LB,  5, 32'h200, 32'h2, 32'h00800000, 32'hFFFFFF80);
    do_load(LS_LBU, 6, 32'h200, 32'h2, 32'h00800000, 32'h00000080);
    do_load(LS_LB,  7, 32'h200, 32'h1, 32'h00007F00, 32'h0000007F);
    do_load(LS_LH,  8, 32'h1FE, 32'h4, 32'h80010000, 32'hFFFF8001);
    do_load(LS_LHU, 9, 32'h202, 32'h0, 32'h80010000, 32'h00008001);
    do_load(LS_LW,  3, 32'h300, 32'h8, 32'hDEADBEEF, 32'hDEADBEEF);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    d_req_ready = 0;
    drive(LS_LW, 2, 32'h100, 32'h2, 0, 0); #1;
    n_chk++; if ({req_ready, d_req_valid} !== 2'b10) begin n_fail++; $display("FAIL mis_hs got %b want 10", {req_ready, d_req_valid}); end
    @(posedge clk); #1;
    n_chk++; if ({misalign, misalign_addr} !== {1'b1, 32'h102}) begin n_fail++; $display("FAIL mis_lw got %b/%h want 1/00000102", misalign, misalign_addr); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mis_busy got %b want 0", busy); end
    @(negedge clk);
    d_req_ready = 1;
    drive(LS_SH, 0, 32'h100, 0, 32'h1, 32'h55); #1;
    n_chk++; if (d_req_valid !== 1'b0) begin n_fail++; $display("FAIL mis_sh_req got %b want 0", d_req_valid); end
    @(posedge clk); #1;
    n_chk++; if ({misalign, misalign_addr} !== {1'b1, 32'h101}) begin n_fail++; $display("FAIL mis_sh got %b/%h want 1/00000101", misalign, misalign_addr); end
    @(negedge clk);
    req_valid = 0;
    @(posedge clk); #1;
    n_chk++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got %b want 0", misalign); end
  endtask

  task automatic test_nop();
    @(negedge clk);
    drive(ls_op_t'(4'hF), 1, 32'h101, 32'h0, 0, 0); #1;
    n_chk++; if ({req_ready, d_req_valid} !== 2'b10) begin n_fail++; $display("FAIL nop_hs got %b want 10", {req_ready, d_req_valid}); end
    @(posedge clk); #1;
    n_chk++; if ({busy, misalign} !== 2'b00) begin n_fail++; $display("FAIL nop_state got %b want 00", {busy, misalign}); end
    req_valid = 0;
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      drive(LS_LW, 4'(i), 32'h300 + 32'(4 * i), 0, 0, 0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(LS_LW, 5, 32'h314, 0, 0, 0);
    d_rsp_valid = 1; d_rd_data = 32'h11111111; #1;
    n_chk++; if ({req_ready, d_req_valid, busy} !== 3'b001) begin n_fail++; $display("FAIL full_hold got %b want 001", {req_ready, d_req_valid, busy}); end
    @(posedge clk); #1;
    n_chk++; if ({ld_valid, ld_rd, ld_data} !== {1'b1, 4'd1, 32'h11111111}) begin n_fail++; $display("FAIL full_pop got %b/%0d/%h want 1/1/11111111", ld_valid, ld_rd, ld_data); end
    @(negedge clk);
    d_rsp_valid = 0; #1;
    n_chk++; if ({req_ready, d_req_valid} !== 2'b11) begin n_fail++; $display("FAIL full_release got %b want 11", {req_ready, d_req_valid}); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    for (int j = 2; j <= 5; j++) begin
      d_rsp_valid = 1; d_rd_data = 32'(j * 16'h1111);
      @(posedge clk); #1;
      n_chk++; if ({ld_valid, ld_rd, ld_data} !== {1'b1, 4'(j), 32'(j * 16'h1111)}) begin n_fail++; $display("FAIL drain_%0d got %b/%0d/%h", j, ld_valid, ld_rd, ld_data); end
      @(negedge clk);
    end
    d_rsp_valid = 0; #1;
    n_chk++; if ({busy, rsp_err} !== 2'b00) begin n_fail++; $display("FAIL drain_end got %b want 00", {busy, rsp_err}); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(LS_LB, 4'(i + 10), 32'h400, 32'(i), 0, 0);
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 0;
    drive(LS_LW, 1, 32'h500, 0, 0, 0); #1;
    n_chk++; if ({ld_valid, ld_rd, ld_data} !== 37'h0) begin n_fail++; $display("FAIL rstm_ld got %b/%0d/%h want 0", ld_valid, ld_rd, ld_data); end
    n_chk++; if ({misalign, misalign_addr, rsp_err, busy} !== 35'h0) begin n_fail++; $display("FAIL rstm_misc got %b/%h/%b/%b want 0", misalign, misalign_addr, rsp_err, busy); end
    n_chk++; if ({req_ready, d_req_valid} !== 2'b11) begin n_fail++; $display("FAIL rstm_comb got %b want 11", {req_ready, d_req_valid}); end
    @(negedge clk);
    req_valid = 0; rst_n = 1;
    @(negedge clk);
    d_rsp_valid = 1; d_rd_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    n_chk++; if ({rsp_err, ld_valid} !== 2'b10) begin n_fail++; $display("FAIL late_rsp got %b want 10", {rsp_err, ld_valid}); end
    @(negedge clk);
    d_rsp_valid = 0;
    @(posedge clk); #1;
    n_chk++; if ({rsp_err, busy} !== 2'b10) begin n_fail++; $display("FAIL err_sticky got %b want 10", {rsp_err, busy}); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_nop();
    test_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
